// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder sequencer: FSM state width and encoding.
package serial_adder_pkg;

    localparam int ST_W = 2;

    typedef logic [ST_W-1:0] state_t;

    localparam state_t ST_IDLE = 2'b00;
    localparam state_t ST_RUN  = 2'b01;
    localparam state_t ST_DONE = 2'b10;

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Requester <-> sequencer handshake bundle. The sub select exists only when
// SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

`ifdef SERIAL_ADDER_SUB_EN
    modport master (output start, a, b, sub, input  busy, done, sum, cout);
    modport slave  (input  start, a, b, sub, output busy, done, sum, cout);
`else
    modport master (output start, a, b, input  busy, done, sum, cout);
    modport slave  (input  start, a, b, output busy, done, sum, cout);
`endif

endinterface

// File: rtl/fa_cell.sv
// Combinational one-bit full adder shared by every bit position of the serial add.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ cin;
    assign co = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one fa_cell walks the operands LSB first, one bit per clock.
// Define SERIAL_ADDER_SUB_EN to add the sub port (a - b as a + ~b + 1).
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_adder_ctrl_if.slave   bus
);

    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   s_sh_q, s_sh_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               sub_q, sub_d;

    logic               sub_in;
    logic               fa_b, fa_s, fa_co;
    logic               last_bit;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_in = bus.sub;
`else
    assign sub_in = 1'b0;
`endif

    // Subtraction inverts B on the fly; the +1 comes from the preset carry.
    assign fa_b     = b_sh_q[0] ^ sub_q;
    assign last_bit = (cnt_q == CNT_LAST);

    fa_cell u_fa (
        .a   (a_sh_q[0]),
        .b   (fa_b),
        .cin (carry_q),
        .s   (fa_s),
        .co  (fa_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.start) state_d = ST_RUN;
            ST_RUN:  if (last_bit)  state_d = ST_DONE;
            ST_DONE:                state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        s_sh_d  = s_sh_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        sub_d   = sub_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.b;
                    cnt_d   = '0;
                    carry_d = sub_in;
                    sub_d   = sub_in;
                end
            end
            ST_RUN: begin
                s_sh_d  = {fa_s, s_sh_q[WIDTH-1:1]};
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                carry_d = fa_co;
                // Counter parks at WIDTH-1 so it never wraps for power-of-two widths.
                if (last_bit) begin
                    sum_d  = s_sh_d;
                    cout_d = fa_co;
                end else begin
                    cnt_d  = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_sh_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            sub_q   <= 1'b0;
        end else begin
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            s_sh_q  <= s_sh_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            sub_q   <= sub_d;
        end
    end

    always_comb begin
        bus.busy = (state_q == ST_RUN) || (state_q == ST_DONE);
        bus.done = (state_q == ST_DONE);
        bus.sum  = sum_q;
        bus.cout = cout_q;
    end

endmodule
